// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered Rijndael ShiftRows / InvShiftRows stage with a
// two-entry skid buffer (main register M, skid register S), one-cycle latency
// and full throughput. The permutation is applied on the input side, so both
// registers hold already-permuted states.
//
// Build option: define SHIFT_ROWS_INV_EN to honour in_mode (both permutation
// networks built and muxed, mode bit stored with each entry). Without it only
// ShiftRows is built and in_mode is ignored.
//
// Parameters:
//   NB     number of state columns (4, 6 or 8); state width is 32*NB
//   TAG_W  width of the sideband tag
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      upstream handshake (in_ready is a register output)
//   in_state/in_mode/in_tag  input state (byte k at [32*NB-1-8k -: 8],
//                          row k%4, column k/4), direction, sideband tag
//   out_valid/out_ready    downstream handshake
//   out_state/out_tag      permuted state and its tag, driven from M
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_state,
  input  logic              in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_state,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int          W   = 32 * NB;
  localparam int unsigned NBU = NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  // Row offset: rows 2 and 3 shift further for the 256-bit block.
  function automatic int unsigned row_off(input int unsigned row);
    case (row)
      0:       row_off = 0;
      1:       row_off = 1;
      2:       row_off = (NBU == 8) ? 3 : 2;
      default: row_off = (NBU == 8) ? 4 : 3;
    endcase
  endfunction

  function automatic logic [W-1:0] permute(input logic [W-1:0] s, input logic inv);
    logic [W-1:0] r;
    int unsigned  src;
    r = '0;
    for (int unsigned c = 0; c < NBU; c++) begin
      for (int unsigned rr = 0; rr < 4; rr++) begin
        if (inv) src = (c + NBU - row_off(rr)) % NBU;
        else     src = (c + row_off(rr)) % NBU;
        r[W-1-8*(c*4+rr) -: 8] = s[W-1-8*(src*4+rr) -: 8];
      end
    end
    return r;
  endfunction

  logic [W-1:0] perm_in;

`ifdef SHIFT_ROWS_INV_EN
  logic [W-1:0] perm_fwd;
  logic [W-1:0] perm_inv;
  assign perm_fwd = permute(in_state, 1'b0);
  assign perm_inv = permute(in_state, 1'b1);
  assign perm_in  = in_mode ? perm_inv : perm_fwd;
`else
  logic unused_mode;
  assign perm_in     = permute(in_state, 1'b0);
  assign unused_mode = in_mode;
`endif

  occ_e             occ, occ_nxt;
  logic             in_ready_q;
  logic [W-1:0]     m_state, s_state;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             in_fire, out_fire;
  logic             load_m_in, load_m_s, load_s;

  assign in_ready  = in_ready_q;
  assign out_valid = (occ != EMPTY);
  assign out_state = m_state;
  assign out_tag   = m_tag;
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    occ_nxt   = occ;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    case (occ)
      EMPTY: begin
        if (in_fire) begin
          load_m_in = 1'b1;
          occ_nxt   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_m_in = 1'b1;
        end else if (in_fire) begin
          load_s  = 1'b1;
          occ_nxt = FULL;
        end else if (out_fire) begin
          occ_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain of S into M can happen.
        if (out_fire) begin
          load_m_s = 1'b1;
          occ_nxt  = ONE;
        end
      end
      default: occ_nxt = EMPTY;
    endcase
  end

`ifdef SHIFT_ROWS_INV_EN
  logic m_mode, s_mode;
  logic [1:0] unused_mode_bits;
  assign unused_mode_bits = {m_mode, s_mode};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= EMPTY;
      in_ready_q <= 1'b1;
      m_state    <= '0;
      m_tag      <= '0;
      s_state    <= '0;
      s_tag      <= '0;
`ifdef SHIFT_ROWS_INV_EN
      m_mode     <= 1'b0;
      s_mode     <= 1'b0;
`endif
    end else begin
      occ        <= occ_nxt;
      // Registered so in_ready has no combinational path from out_ready.
      in_ready_q <= (occ_nxt != FULL);
      if (load_m_in) begin
        m_state <= perm_in;
        m_tag   <= in_tag;
`ifdef SHIFT_ROWS_INV_EN
        m_mode  <= in_mode;
`endif
      end else if (load_m_s) begin
        m_state <= s_state;
        m_tag   <= s_tag;
`ifdef SHIFT_ROWS_INV_EN
        m_mode  <= s_mode;
`endif
      end
      if (load_s) begin
        s_state <= perm_in;
        s_tag   <= in_tag;
`ifdef SHIFT_ROWS_INV_EN
        s_mode  <= in_mode;
`endif
      end
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

`ifdef SHIFT_ROWS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [127:0] in_state, out_state;
  logic [3:0]   in_tag, out_tag;

  logic         v8, r8, m8, ov8;
  logic [255:0] s8, os8;
  logic [3:0]   t8, ot8;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_tag(out_tag)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(v8), .in_ready(r8), .in_state(s8),
    .in_mode(m8), .in_tag(t8),
    .out_valid(ov8), .out_ready(1'b1),
    .out_state(os8), .out_tag(ot8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   tag;
  } exp_t;
  exp_t q[$];

  bit           stall_prev = 1'b0;
  logic [127:0] prev_state;
  logic [3:0]   prev_tag;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference ShiftRows on a byte grid: out[r][c] = in[r][(c +/- off[r]) mod nb].
  function automatic logic [255:0] ref_perm(input logic [255:0] s, input int nb, input bit inv);
    logic [7:0]   grid [4][8];
    int           off  [4];
    logic [255:0] r;
    int           src;
    if (nb == 8) off = '{0, 1, 3, 4};
    else         off = '{0, 1, 2, 3};
    for (int k = 0; k < 4*nb; k++) grid[k%4][k/4] = s[32*nb-1-8*k -: 8];
    r = '0;
    for (int c = 0; c < nb; c++) begin
      for (int row = 0; row < 4; row++) begin
        src = inv ? (c - off[row] + nb) % nb : (c + off[row]) % nb;
        r[32*nb-1-8*(c*4+row) -: 8] = grid[row][src];
      end
    end
    return r;
  endfunction

  // One clock of the NB=4 DUT: drive at the falling edge, check registered
  // outputs against a depth-2 FIFO model, then update the model for the edge.
  task automatic cycle(input bit iv, input logic [127:0] st, input bit md,
                       input logic [3:0] tg, input bit ordy, input bit rs);
    logic [255:0] p;
    bit           rdy;
    exp_t         e;
    @(negedge clk);
    in_valid = iv; in_state = st; in_mode = md; in_tag = tg;
    out_ready = ordy; rst = rs;
    rdy = (q.size() < 2);
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, q.size() > 0);
    if (stall_prev) begin
      chk("stall_state", out_state, prev_state);
      chk("stall_tag", out_tag, prev_tag);
    end
    stall_prev = 1'b0;
    if (rs) begin
      q.delete();
      return;
    end
    if (q.size() > 0 && ordy) begin
      e = q.pop_front();
      chk("out_state", out_state, e.st);
      chk("out_tag", out_tag, e.tag);
    end else if (q.size() > 0) begin
      stall_prev = 1'b1;
      prev_state = out_state;
      prev_tag   = out_tag;
    end
    if (iv && rdy) begin
      p = ref_perm({128'b0, st}, 4, md & INV_EN);
      e.st  = p[127:0];
      e.tag = tg;
      q.push_back(e);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] p, orig8, tmp8;
    int           i, vcount;
    bit           ready_low;

    rst = 1'b1; in_valid = 1'b0; in_state = '0; in_mode = 1'b0; in_tag = '0;
    out_ready = 1'b0; v8 = 1'b0; s8 = '0; m8 = 1'b0; t8 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_state", out_state, '0);
    chk("rst_out_tag", out_tag, '0);
    chk("rst_out_valid8", ov8, 1'b0);

    // FIPS-197 forward vector
    cycle(1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'hA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("fips_fwd", out_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    chk("fips_fwd_tag", out_tag, 4'hA);

    // Inverse round trip (or forward when the inverse network is absent)
    p = ref_perm({128'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5}, 4, 1'b0);
    cycle(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'hB, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("fips_inv", out_state, INV_EN ? 256'hd42711aee0bf98f1b8b45de51e415230 : p);
    p = ref_perm({128'b0, 128'h000102030405060708090a0b0c0d0e0f}, 4, 1'b1);
    cycle(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'hC, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("mode1_seq", out_state, INV_EN ? p : 256'h00050a0f04090e03080d02070c01060b);

    // NB=8 offsets and inverse restore
    for (int k = 0; k < 32; k++) orig8[255-8*k -: 8] = 8'(k);
    @(negedge clk);
    v8 = 1'b1; s8 = orig8; m8 = 1'b0; t8 = 4'h5;
    @(negedge clk);
    v8 = 1'b0;
    chk("nb8_valid", ov8, 1'b1);
    chk("nb8_word0", os8[255:224], 32'h00050e13);
    chk("nb8_fwd", os8, ref_perm(orig8, 8, 1'b0));
    chk("nb8_tag", ot8, 4'h5);
    tmp8 = os8;
    v8 = 1'b1; s8 = tmp8; m8 = 1'b1; t8 = 4'h6;
    @(negedge clk);
    v8 = 1'b0;
    chk("nb8_inv", os8, INV_EN ? orig8 : ref_perm(tmp8, 8, 1'b0));
    chk("nb8_inv_tag", ot8, 4'h6);
    @(negedge clk);
    chk("nb8_drain", ov8, 1'b0);

    // Backpressure: tags 0..7 with random out_ready
    i = 0;
    for (int n = 0; n < 300 && (i < 8 || q.size() > 0); n++) begin
      bit iv, rdy;
      iv  = (i < 8);
      rdy = (q.size() < 2);
      cycle(iv, rnd128(), 1'($urandom_range(0, 1)), 4'(i), 1'($urandom_range(0, 1)), 1'b0);
      if (iv && rdy) i++;
    end
    chk("bp_complete", {i == 8, q.size() == 0}, 2'b11);

    // Full throughput: 16 back-to-back with out_ready high
    vcount = 0;
    ready_low = 1'b0;
    for (int n = 0; n < 17; n++) begin
      cycle(n < 16, rnd128(), 1'($urandom_range(0, 1)), 4'(n), 1'b1, 1'b0);
      if (n > 0 && out_valid) vcount++;
      if (!in_ready) ready_low = 1'b1;
    end
    chk("tput_valid_cycles", vcount, 16);
    chk("tput_ready_low", ready_low, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom_range(0, 1)), rnd128(), 1'($urandom_range(0, 1)),
            4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    for (int n = 0; n < 10 && q.size() > 0; n++)
      cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("rand_drained", q.size(), 0);

    // Reset mid-stream with tags 3 and 4 held
    cycle(1'b1, rnd128(), 1'b0, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 4'h4, 1'b0, 1'b0);
    cycle(1'b1, rnd128(), 1'b0, 4'h9, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_state", out_state, '0);
    chk("mid_rst_out_tag", out_tag, '0);
    cycle(1'b1, 128'h00112233445566778899aabbccddeeff, 1'b0, 4'h7, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_rst_tag", out_tag, 4'h7);
    cycle(1'b0, '0, 1'b0, 4'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_rows_pipe.md
# shift_rows_pipe

- Registered, parametrised Rijndael ShiftRows / InvShiftRows stage for the AES datapath.
- Supports block widths of 4, 6 or 8 columns (128/192/256-bit Rijndael state).
- Direction is selected per transaction by a `mode` bit; a `tag` is carried alongside each state.
- A valid/ready handshake with a two-entry skid buffer gives full throughput and one-cycle latency, so the stage can sit between SubBytes and MixColumns in a pipelined round.

## Interface

Parameters:
- `NB`, 4: number of state columns; legal values are 4, 6 and 8. State width is `32*NB`.
- `TAG_W`, 4: width of the sideband tag passed through with each state.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream has a state.
- `in_ready`  out  1  stage can accept a state.
- `in_state`  in  `32*NB`  input state; byte k sits at `[32*NB-1-8k -: 8]`, row = k%4, column = k/4.
- `in_mode`  in  1  0 = ShiftRows (forward), 1 = InvShiftRows.
- `in_tag`  in  `TAG_W`  sideband tag.
- `out_valid`  out  1  output holds a state.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  `32*NB`  permuted state, same byte layout as `in_state`.
- `out_tag`  out  `TAG_W`  tag of the state currently on `out_state`.

## Operation

- Row offsets:
  - NB=4 or 6: {0,1,2,3}.
  - NB=8: {0,1,3,4}.
  - An illegal NB stops elaboration with a `$error` in a generate block.
- Forward: `out[r][c] = in[r][(c+off[r]) mod NB]`.
- Inverse: `out[r][c] = in[r][(c-off[r]+NB) mod NB]`.
- The permutation is applied combinationally on the input side; registers hold permuted data only.
- Storage is a main output register M plus a skid register S. Each holds {state, tag, valid}.
- Occupancy states:
  - EMPTY: M and S invalid.
  - ONE: M valid, S invalid.
  - FULL: M and S valid.
- `in_ready` = S invalid; it is a direct register output with no combinational path from `out_ready`.
- `out_valid` = M valid; `out_state` and `out_tag` are driven from M.
- Transitions (in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`):
  - EMPTY, in_fire: M ← input, go to ONE.
  - ONE, in_fire and out_fire: M ← input, stay in ONE.
  - ONE, in_fire only: S ← input, go to FULL.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: M ← S, go to ONE. `in_ready` is low in FULL, so there is no input in the same cycle.
- Data order is strict FIFO. No state or tag is duplicated or dropped.
- `mode` is sampled with its state. Interleaved forward and inverse transactions are legal back-to-back.
- Reset:
  - `rst` high at a clock edge clears M.valid and S.valid; any in-flight data is discarded.
  - Reset values: `out_valid`=0, `in_ready`=1, `out_state`=0, `out_tag`=0. Data registers are cleared too.
  - While `rst` is high, `in_valid` is ignored and nothing is accepted.

## Timing

- Latency: a state accepted at edge N appears with `out_valid`=1 after edge N.
- Throughput: one state per cycle while `out_ready` stays high.
- `out_state` and `out_tag` stay stable while `out_valid & !out_ready`. The bench asserts this.
- A single `out_ready` low cycle absorbs one extra input into S. `in_ready` falls after the edge at which S fills.
- `in_ready` returns high the cycle after the out_fire that drains S.

## Configuration

- `SHIFT_ROWS_INV_EN` defined:
  - `in_mode` is honoured.
  - A mode bit is stored in M and S alongside the state.
  - Both permutation networks are built and muxed.
- `SHIFT_ROWS_INV_EN` undefined:
  - Only the forward network is built.
  - `in_mode` is ignored and every transaction is ShiftRows.
  - The port stays present for pin compatibility.

## Test plan

- **FIPS-197 forward, NB=4:** `d42711aee0bf98f1b8b45de51e415230`, mode 0, `out_ready`=1 → `d4bf5d30e0b452aeb84111f11e2798e5` one cycle later, tag preserved.
- **Inverse round trip (macro defined):** `d4bf5d30e0b452aeb84111f11e2798e5`, mode 1 → `d42711aee0bf98f1b8b45de51e415230`. Without the macro, mode 1 on input `000102…0f` → `00050a0f04090e03080d02070c01060b`.
- **NB=8 offsets:** input bytes `00..1f` (byte k = k), forward → first output word `00050e13`. Inverse of that output restores `00..1f`.
- **Backpressure:** stream 8 states, tags 0..7, while toggling `out_ready` pseudo-randomly.
  - Outputs appear in tag order 0..7 with correct data.
  - `in_ready` drops only when both entries are full.
  - Output is stable while stalled.
- **Full throughput:** 16 back-to-back states with `out_ready` held high → 16 consecutive `out_valid` cycles and `in_ready` never low.
- **Reset mid-stream:** FULL with tags 3 and 4; assert `rst` for one cycle → next cycle `out_valid`=0, `in_ready`=1, `out_state`=0. Tags 3 and 4 are never emitted, and a new state sent after reset emerges correctly.
